// File: rtl/perf_counter_bank_if.sv
// Interface for the performance counter bank: count controls from the pipeline
// side and readout toward the debug/MMIO logic.
interface perf_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
    logic              enable;
    logic [NUM_CH-1:0] event_in;
    logic [NUM_CH-1:0] clear_in;
    logic              clear_all;
    logic              snapshot;
    logic [SEL_W-1:0]  read_sel;
    logic              read_live;
    logic [WIDTH-1:0]  read_data;
    logic [NUM_CH-1:0] overflow;
    logic              snap_valid;

    modport master (
        output enable, event_in, clear_in, clear_all, snapshot, read_sel, read_live,
        input  read_data, overflow, snap_valid
    );

    modport slave (
        input  enable, event_in, clear_in, clear_all, snapshot, read_sel, read_live,
        output read_data, overflow, snap_valid
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank with sticky overflow, wrap/saturate option
// and a global snapshot into shadow registers for coherent readout.
module perf_counter_bank #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int SATURATE  = 0,
    parameter int EDGE_MODE = 1,
    parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic                clk,
    input logic                reset_n,
    perf_counter_bank_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]  count  [NUM_CH];
    logic [WIDTH-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0] event_prev;
    logic [NUM_CH-1:0] overflow;
    logic              snap_valid;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] inc;
    logic [WIDTH-1:0]  read_data;

    assign hit = (EDGE_MODE != 0) ? (bus.event_in & ~event_prev) : bus.event_in;
    assign inc = {NUM_CH{bus.enable}} & hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_prev <= '0;
            overflow   <= '0;
            snap_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]  <= '0;
                shadow[i] <= '0;
            end
        end else begin
            // Edge history tracks even while disabled so a held event never
            // looks like a fresh edge when enable returns.
            event_prev <= bus.event_in;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.clear_all || bus.clear_in[i]) begin
                    count[i]    <= '0;
                    overflow[i] <= 1'b0;
                end else if (inc[i]) begin
                    if (count[i] == CNT_MAX) begin
                        overflow[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            count[i] <= '0;
                        end
                    end else begin
                        count[i] <= count[i] + 1'b1;
                    end
                end
            end
            // Shadows capture the pre-update counts; per-channel clears leave them alone.
            if (bus.clear_all) begin
                snap_valid <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow[i] <= '0;
                end
            end else if (bus.snapshot) begin
                snap_valid <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow[i] <= count[i];
                end
            end
        end
    end

    // Compare-based mux so out-of-range selects fall through to zero.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.read_sel == SEL_W'(i)) begin
                read_data = bus.read_live ? count[i] : shadow[i];
            end
        end
    end

    assign bus.read_data  = read_data;
    assign bus.overflow   = overflow;
    assign bus.snap_valid = snap_valid;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: four parameterisations driven side by side,
// expected values queued at stimulus time and popped at readout.
module tb_perf_counter_bank;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // m: edge/wrap W16 (SEL_W widened to 3), l: level mode, w: W4 wrap, s: W4 saturate
    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(16), .SEL_W(3)) m_if ();
    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(16), .SEL_W(2)) l_if ();
    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(4),  .SEL_W(2)) w_if ();
    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(4),  .SEL_W(2)) s_if ();

    perf_counter_bank #(.NUM_CH(4), .WIDTH(16), .SATURATE(0), .EDGE_MODE(1), .SEL_W(3))
        u_m (.clk(clk), .reset_n(reset_n), .bus(m_if));
    perf_counter_bank #(.NUM_CH(4), .WIDTH(16), .SATURATE(0), .EDGE_MODE(0), .SEL_W(2))
        u_l (.clk(clk), .reset_n(reset_n), .bus(l_if));
    perf_counter_bank #(.NUM_CH(4), .WIDTH(4), .SATURATE(0), .EDGE_MODE(1), .SEL_W(2))
        u_w (.clk(clk), .reset_n(reset_n), .bus(w_if));
    perf_counter_bank #(.NUM_CH(4), .WIDTH(4), .SATURATE(1), .EDGE_MODE(1), .SEL_W(2))
        u_s (.clk(clk), .reset_n(reset_n), .bus(s_if));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic pop_chk(logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic rd_m(int sel, logic live);
        m_if.read_sel = 3'(sel); m_if.read_live = live; #1;
        pop_chk(32'(m_if.read_data));
    endtask

    task automatic rd_l(int sel);
        l_if.read_sel = 2'(sel); l_if.read_live = 1'b1; #1;
        pop_chk(32'(l_if.read_data));
    endtask

    task automatic rd_w(int sel);
        w_if.read_sel = 2'(sel); w_if.read_live = 1'b1; #1;
        pop_chk(32'(w_if.read_data));
    endtask

    task automatic rd_s(int sel);
        s_if.read_sel = 2'(sel); s_if.read_live = 1'b1; #1;
        pop_chk(32'(s_if.read_data));
    endtask

    task automatic pulse_m(int ch, int n);
        repeat (n) begin
            m_if.event_in[ch] = 1'b1; tick;
            m_if.event_in[ch] = 1'b0; tick;
        end
    endtask

    task automatic pulse_ws(int n);
        repeat (n) begin
            w_if.event_in[0] = 1'b1; s_if.event_in[0] = 1'b1; tick;
            w_if.event_in[0] = 1'b0; s_if.event_in[0] = 1'b0; tick;
        end
    endtask

    task automatic clear_ws0;
        w_if.clear_in[0] = 1'b1; s_if.clear_in[0] = 1'b1; tick;
        w_if.clear_in[0] = 1'b0; s_if.clear_in[0] = 1'b0; tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_if.enable = 1'b1; m_if.event_in = '0; m_if.clear_in = '0; m_if.clear_all = 1'b0;
        m_if.snapshot = 1'b0; m_if.read_sel = '0; m_if.read_live = 1'b1;
        l_if.enable = 1'b1; l_if.event_in = '0; l_if.clear_in = '0; l_if.clear_all = 1'b0;
        l_if.snapshot = 1'b0; l_if.read_sel = '0; l_if.read_live = 1'b1;
        w_if.enable = 1'b1; w_if.event_in = '0; w_if.clear_in = '0; w_if.clear_all = 1'b0;
        w_if.snapshot = 1'b0; w_if.read_sel = '0; w_if.read_live = 1'b1;
        s_if.enable = 1'b1; s_if.event_in = '0; s_if.clear_in = '0; s_if.clear_all = 1'b0;
        s_if.snapshot = 1'b0; s_if.read_sel = '0; s_if.read_live = 1'b1;
        reset_n = 1'b0;
        repeat (2) tick;

        push("rst_live0", 0);   rd_m(0, 1'b1);
        push("rst_shadow0", 0); rd_m(0, 1'b0);
        push("rst_ovf", 0);     pop_chk(32'(m_if.overflow));
        push("rst_snapv", 0);   pop_chk(32'(m_if.snap_valid));
        reset_n = 1'b1;
        tick;

        // Edge mode: held level counts once, three separated pulses count three
        m_if.event_in[0] = 1'b1;
        repeat (5) tick;
        m_if.event_in[0] = 1'b0;
        pulse_m(1, 3);
        tick;
        push("edge_cnt0", 1); push("edge_cnt1", 3); push("edge_cnt2", 0);
        push("edge_cnt3", 0); push("edge_ovf", 0);
        for (int c = 0; c < 4; c++) rd_m(c, 1'b1);
        pop_chk(32'(m_if.overflow));

        // Event already high when enable rises is not an edge
        m_if.enable = 1'b0; m_if.event_in[2] = 1'b1; tick;
        m_if.enable = 1'b1; tick; tick;
        m_if.event_in[2] = 1'b0; tick;
        push("en_held_cnt2", 0); rd_m(2, 1'b1);

        // Level mode: 7 high cycles, then again with enable low for cycles 3-4
        l_if.event_in[2] = 1'b1;
        repeat (7) tick;
        l_if.event_in[2] = 1'b0; tick;
        push("lvl_cnt2", 7); rd_l(2);
        l_if.clear_in[2] = 1'b1; tick;
        l_if.clear_in[2] = 1'b0; tick;
        push("lvl_clr2", 0); rd_l(2);
        l_if.event_in[2] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            l_if.enable = !(c == 3 || c == 4);
            tick;
        end
        l_if.event_in[2] = 1'b0; l_if.enable = 1'b1; tick;
        push("lvl_gated2", 5); rd_l(2);

        // WIDTH=4 wrap vs saturate
        pulse_ws(15);
        push("w_pre15", 15); push("s_pre15", 15); push("w_pre_ovf", 0); push("s_pre_ovf", 0);
        rd_w(0); rd_s(0); pop_chk(32'(w_if.overflow)); pop_chk(32'(s_if.overflow));
        pulse_ws(1);
        push("w_wrap", 0); push("s_sat", 15); push("w_ovf", 1); push("s_ovf", 1);
        rd_w(0); rd_s(0); pop_chk(32'(w_if.overflow)); pop_chk(32'(s_if.overflow));
        clear_ws0;
        push("w_clr", 0); push("s_clr", 0); push("w_clr_ovf", 0); push("s_clr_ovf", 0);
        rd_w(0); rd_s(0); pop_chk(32'(w_if.overflow)); pop_chk(32'(s_if.overflow));

        // Clear beats an overflowing increment in the same cycle
        pulse_ws(15);
        w_if.event_in[0] = 1'b1; s_if.event_in[0] = 1'b1;
        w_if.clear_in[0] = 1'b1; s_if.clear_in[0] = 1'b1; tick;
        w_if.event_in[0] = 1'b0; s_if.event_in[0] = 1'b0;
        w_if.clear_in[0] = 1'b0; s_if.clear_in[0] = 1'b0; tick;
        push("w_clrwin", 0); push("s_clrwin", 0); push("w_clrwin_ovf", 0); push("s_clrwin_ovf", 0);
        rd_w(0); rd_s(0); pop_chk(32'(w_if.overflow)); pop_chk(32'(s_if.overflow));

        // Snapshot coherence
        m_if.clear_all = 1'b1; tick;
        m_if.clear_all = 1'b0;
        pulse_m(0, 9);
        push("snap_pre9", 9); rd_m(0, 1'b1);
        m_if.event_in[0] = 1'b1; m_if.snapshot = 1'b1; tick;
        m_if.event_in[0] = 1'b0; m_if.snapshot = 1'b0;
        push("snap_shadow0", 9); push("snap_live0", 10); push("snap_shadow1", 0); push("snap_valid", 1);
        rd_m(0, 1'b0); rd_m(0, 1'b1); rd_m(1, 1'b0); pop_chk(32'(m_if.snap_valid));
        m_if.clear_in[0] = 1'b1; tick;
        m_if.clear_in[0] = 1'b0; tick;
        push("clr_live0", 0); push("clr_keep_shadow0", 9);
        rd_m(0, 1'b1); rd_m(0, 1'b0);

        // Clear beats a same-cycle edge
        pulse_m(3, 2);
        push("pri_pre3", 2); rd_m(3, 1'b1);
        m_if.clear_in[3] = 1'b1; m_if.event_in[3] = 1'b1; tick;
        m_if.clear_in[3] = 1'b0; m_if.event_in[3] = 1'b0; tick;
        push("pri_clr3", 0); rd_m(3, 1'b1);

        // clear_all beats snapshot
        m_if.clear_all = 1'b1; m_if.snapshot = 1'b1; tick;
        m_if.clear_all = 1'b0; m_if.snapshot = 1'b0; tick;
        push("ca_shadow0", 0); push("ca_snapv", 0);
        rd_m(0, 1'b0); pop_chk(32'(m_if.snap_valid));

        // Out-of-range select reads zero even though the aliased channel is nonzero
        pulse_m(1, 2);
        push("sel1_live", 2); push("sel5_live", 0); push("sel5_shadow", 0);
        rd_m(1, 1'b1); rd_m(5, 1'b1); rd_m(5, 1'b0);

        // Asynchronous reset between edges, then release with event held high
        pulse_ws(16);
        push("pre_rst_w_ovf", 1); push("pre_rst_s_cnt", 15);
        pop_chk(32'(w_if.overflow)); rd_s(0);
        tick;
        reset_n = 1'b0;
        push("arst_m_cnt1", 0); push("arst_s_cnt0", 0); push("arst_w_ovf", 0); push("arst_s_ovf", 0);
        rd_m(1, 1'b1); rd_s(0); pop_chk(32'(w_if.overflow)); pop_chk(32'(s_if.overflow));
        m_if.event_in[0] = 1'b1;
        reset_n = 1'b1;
        tick;
        push("rel_cnt0", 1); rd_m(0, 1'b1);
        tick;
        push("rel_hold_cnt0", 1); rd_m(0, 1'b1);
        m_if.event_in[0] = 1'b0;

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
